fmps_write_link: RTL

Transmitter end of the Fast MPS (FMPS) cell-controller link protocol. On each Aurora-domain FA strobe, the block builds one FMPS packet and drives it onto an AXI4-Stream Aurora TX port, honouring TREADY backpressure. A packet is a header word, a fixed number of payload words sampled at the strobe, and a closing checksum word. The block sits in the Aurora user clock domain, one instance per outgoing link (CCW/CW), upstream of the link tap observed by the FMPS link readers.

---
 rtl/fmps_write_link.sv | 106 ++++++++++
 1 files changed

// File: rtl/fmps_write_link.sv
// fmps_write_link: builds one FMPS packet (header, payload, checksum) per FA strobe
// and streams it onto an Aurora AXI4-Stream TX port under TREADY backpressure.
module fmps_write_link #(
   parameter int         INDEX_WIDTH = 5,
   parameter int         DATA_WORDS  = 2,
   parameter logic [7:0] MAGIC       = 8'hA5
) (
   input  logic                       auClk,
   input  logic                       auReset,
   input  logic                       auFAstrobe,
   input  logic                       auFMPSinhibit,
   input  logic [INDEX_WIDTH-1:0]     fmpsIndex,
   input  logic                       fmpsEnabled,
   input  logic [32*DATA_WORDS-1:0]   fmpsData,
   output logic                       TVALID,
   input  logic                       TREADY,
   output logic                       TLAST,
   output logic [31:0]                TDATA,
   output logic                       auSentStrobe,
   output logic                       auInhibitStrobe,
   output logic                       auOverrunStrobe,
   output logic [7:0]                 auSeqno,
   output logic                       auBusy
);
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;
   state_t                    r_state;
   logic                      r_tvalid, r_tlast, r_sent, r_inh, r_ovr;
   logic [31:0]               r_tdata, r_sum;
   logic [7:0]                r_seqno;
   logic [3:0]                r_cnt;
   logic [32*DATA_WORDS-1:0]  r_data;
   logic                      w_hs, w_end, w_open, w_accept, w_inhibit, w_overrun;
   logic [31:0]               w_sum_next;
   logic [32*DATA_WORDS-1:0]  w_data_next;
   assign w_hs        = r_tvalid & TREADY;
   assign w_end       = (r_state == CHECKSUM) & w_hs;
   // a strobe may start a packet when idle or on the very cycle the last word leaves
   assign w_open      = (r_state == IDLE) | w_end;
   assign w_accept    = auFAstrobe & ~auFMPSinhibit & w_open;
   assign w_inhibit   = auFAstrobe & auFMPSinhibit & w_open;
   assign w_overrun   = auFAstrobe & ~w_open;
   assign w_sum_next  = r_sum + r_tdata;
   assign w_data_next = r_data >> 32;
   always_ff @(posedge auClk) begin
      if (auReset) begin
         r_state  <= IDLE;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
         r_sum    <= '0;
         r_seqno  <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_sent   <= 1'b0;
         r_inh    <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_sent <= w_end;
         r_inh  <= w_inhibit;
         r_ovr  <= w_overrun;
         if (w_accept) begin
            r_state  <= HEADER;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_tdata  <= {MAGIC, fmpsEnabled, 7'd0, 8'(fmpsIndex), r_seqno};
            r_data   <= fmpsData;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_seqno  <= r_seqno + 8'd1;
         end else if (w_hs) begin
            case (r_state)
               HEADER: begin
                  r_state <= PAYLOAD;
                  r_sum   <= w_sum_next;
                  r_tdata <= r_data[31:0];
               end
               PAYLOAD: begin
                  r_sum <= w_sum_next;
                  if (r_cnt == 4'(DATA_WORDS - 1)) begin
                     r_state <= CHECKSUM;
                     r_tlast <= 1'b1;
                     r_tdata <= -w_sum_next;
                  end else begin
                     r_cnt   <= r_cnt + 4'd1;
                     r_tdata <= w_data_next[31:0];
                     r_data  <= w_data_next;
                  end
               end
               default: begin
                  r_state  <= IDLE;
                  r_tvalid <= 1'b0;
                  r_tlast  <= 1'b0;
               end
            endcase
         end
      end
   end
   assign TVALID          = r_tvalid;
   assign TLAST           = r_tlast;
   assign TDATA           = r_tdata;
   assign auSentStrobe    = r_sent;
   assign auInhibitStrobe = r_inh;
   assign auOverrunStrobe = r_ovr;
   assign auSeqno         = r_seqno;
   assign auBusy          = r_state != IDLE;
endmodule
